// File: rtl/if_id_ex_front.sv
// ---------------------------------------------------------------------------
// if_id_ex_front
//   Front half of an 8-bit, 5-stage pipeline: instruction fetch (IF),
//   decode plus 4x8 register file (ID) and execute (EX). The EX/MEM pipeline
//   register drives the outputs consumed by the MEM stage.
//
// Ports
//   clock        in   1  rising-edge clock
//   rst_n        in   1  asynchronous active-low reset
//   imem_addr    out  8  current PC (combinational instruction read address)
//   imem_data    in   8  instruction byte at imem_addr
//   pcj_mux      in   8  redirect target from MEM
//   choice_mux   in   1  redirect taken; squashes IF/ID, ID/EX and EX/MEM
//   wb_data      in   8  writeback value
//   wb_we        in   1  writeback enable
//   wb_rd        in   2  writeback register index
//   zeroOut      out  1  ALU result == 0
//   acOutValue   out  8  ALU result, or memory address for LW/SW
//   ulaJumpOut   out  8  branch/jump target
//   rs           out  8  store data R[rd]
//   rdOut        out  2  destination register
//   WRMem, WMMem, RMMem, NEQMem, JMem, JCMem  out 1  control flags
//
// Instruction byte: [7:5] op, [4:3] rd, [2:0] funct/imm3. 8'h00 is a NOP.
//
// Build option
//   EX_FWD_EN : when defined, EX operands A, B and the store data are taken
//               from acOutValue when the instruction now in EX/MEM writes a
//               register (WRMem=1, RMMem=0) that matches the source register.
// ---------------------------------------------------------------------------
module if_id_ex_front #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clock,
  input  logic       rst_n,
  output logic [7:0] imem_addr,
  input  logic [7:0] imem_data,
  input  logic [7:0] pcj_mux,
  input  logic       choice_mux,
  input  logic [7:0] wb_data,
  input  logic       wb_we,
  input  logic [1:0] wb_rd,
  output logic       zeroOut,
  output logic [7:0] acOutValue,
  output logic [7:0] ulaJumpOut,
  output logic [7:0] rs,
  output logic [1:0] rdOut,
  output logic       WRMem,
  output logic       WMMem,
  output logic       RMMem,
  output logic       NEQMem,
  output logic       JMem,
  output logic       JCMem
);

  localparam logic [2:0] OP_ALU  = 3'd0;
  localparam logic [2:0] OP_ADDI = 3'd1;
  localparam logic [2:0] OP_LI   = 3'd2;
  localparam logic [2:0] OP_LW   = 3'd3;
  localparam logic [2:0] OP_SW   = 3'd4;
  localparam logic [2:0] OP_J    = 3'd5;
  localparam logic [2:0] OP_BEQ  = 3'd6;
  localparam logic [2:0] OP_BNE  = 3'd7;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;

  // ---------------------------------------------------------------- IF
  logic [7:0] r_pc;
  logic [7:0] w_pc_inc;
  logic [7:0] r_ifid_instr;
  logic [7:0] r_ifid_pc1;

  assign w_pc_inc  = r_pc + 8'd1;
  assign imem_addr = r_pc;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= choice_mux ? pcj_mux : w_pc_inc;
    end
  end

  // A squashed slot is simply loaded with the NOP encoding 8'h00.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_ifid_instr <= '0;
      r_ifid_pc1   <= '0;
    end else if (choice_mux) begin
      r_ifid_instr <= '0;
      r_ifid_pc1   <= '0;
    end else begin
      r_ifid_instr <= imem_data;
      r_ifid_pc1   <= w_pc_inc;
    end
  end

  // ---------------------------------------------------------------- ID
  logic [7:0] r_regs [0:3];
  logic [2:0] w_op;
  logic [1:0] w_rd;
  logic [2:0] w_funct;
  logic [7:0] w_sx3;
  logic [7:0] w_sx5;
  logic       w_nop;
  logic [7:0] w_rd_val;
  logic [7:0] w_r0_val;
  logic       w_wr, w_wm, w_rm, w_neq, w_j, w_jc;
  logic       w_ina, w_sin, w_sout;
  logic [2:0] w_alu_op;
  logic [7:0] w_id_a;
  logic [7:0] w_id_b;
  logic [7:0] w_id_off;

  assign w_op    = r_ifid_instr[7:5];
  assign w_rd    = r_ifid_instr[4:3];
  assign w_funct = r_ifid_instr[2:0];
  assign w_sx3   = {{5{r_ifid_instr[2]}}, r_ifid_instr[2:0]};
  assign w_sx5   = {{3{r_ifid_instr[4]}}, r_ifid_instr[4:0]};
  assign w_nop   = (r_ifid_instr == 8'h00);

  // Write-through: a register being written this cycle reads as the new value.
  assign w_rd_val = (wb_we && (wb_rd == w_rd)) ? wb_data : r_regs[w_rd];
  assign w_r0_val = (wb_we && (wb_rd == 2'd0)) ? wb_data : r_regs[0];

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r_regs[i] <= '0;
    end else if (wb_we) begin
      r_regs[wb_rd] <= wb_data;
    end
  end

  // INA forces A to zero, SIN selects R0 as A, SOUT selects sx3 as B.
  always_comb begin
    w_wr     = 1'b0;
    w_wm     = 1'b0;
    w_rm     = 1'b0;
    w_neq    = 1'b0;
    w_j      = 1'b0;
    w_jc     = 1'b0;
    w_ina    = 1'b0;
    w_sin    = 1'b0;
    w_sout   = 1'b0;
    w_alu_op = ALU_ADD;
    if (!w_nop) begin
      case (w_op)
        OP_ALU:  begin w_wr = 1'b1; w_alu_op = w_funct; end
        OP_ADDI: begin w_wr = 1'b1; w_sout = 1'b1; end
        OP_LI:   begin w_wr = 1'b1; w_ina = 1'b1; w_sout = 1'b1; end
        OP_LW:   begin w_wr = 1'b1; w_rm = 1'b1; w_sin = 1'b1; w_sout = 1'b1; end
        OP_SW:   begin w_wm = 1'b1; w_sin = 1'b1; w_sout = 1'b1; end
        OP_J:    begin w_j = 1'b1; end
        OP_BEQ:  begin w_jc = 1'b1; w_alu_op = ALU_SUB; end
        OP_BNE:  begin w_jc = 1'b1; w_neq = 1'b1; w_alu_op = ALU_SUB; end
        default: ;
      endcase
    end
  end

  assign w_id_a   = w_ina ? 8'h00 : (w_sin ? w_r0_val : w_rd_val);
  assign w_id_b   = w_sout ? w_sx3 : w_r0_val;
  assign w_id_off = w_j ? w_sx5 : w_sx3;

  // ID/EX register
  logic       r_idex_live;
  logic [7:0] r_idex_a;
  logic [7:0] r_idex_b;
  logic [7:0] r_idex_rs;
  logic [1:0] r_idex_rd;
  logic [2:0] r_idex_alu_op;
  logic [7:0] r_idex_off;
  logic [7:0] r_idex_pc1;
  logic       r_idex_wr, r_idex_wm, r_idex_rm, r_idex_neq, r_idex_j, r_idex_jc;
`ifdef EX_FWD_EN
  logic [1:0] r_idex_a_src;
  logic       r_idex_a_reg;
  logic       r_idex_b_reg;
`endif

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_idex_live   <= 1'b0;
      r_idex_a      <= '0;
      r_idex_b      <= '0;
      r_idex_rs     <= '0;
      r_idex_rd     <= '0;
      r_idex_alu_op <= '0;
      r_idex_off    <= '0;
      r_idex_pc1    <= '0;
      r_idex_wr     <= 1'b0;
      r_idex_wm     <= 1'b0;
      r_idex_rm     <= 1'b0;
      r_idex_neq    <= 1'b0;
      r_idex_j      <= 1'b0;
      r_idex_jc     <= 1'b0;
`ifdef EX_FWD_EN
      r_idex_a_src  <= '0;
      r_idex_a_reg  <= 1'b0;
      r_idex_b_reg  <= 1'b0;
`endif
    end else if (choice_mux || w_nop) begin
      r_idex_live   <= 1'b0;
      r_idex_a      <= '0;
      r_idex_b      <= '0;
      r_idex_rs     <= '0;
      r_idex_rd     <= '0;
      r_idex_alu_op <= '0;
      r_idex_off    <= '0;
      r_idex_pc1    <= '0;
      r_idex_wr     <= 1'b0;
      r_idex_wm     <= 1'b0;
      r_idex_rm     <= 1'b0;
      r_idex_neq    <= 1'b0;
      r_idex_j      <= 1'b0;
      r_idex_jc     <= 1'b0;
`ifdef EX_FWD_EN
      r_idex_a_src  <= '0;
      r_idex_a_reg  <= 1'b0;
      r_idex_b_reg  <= 1'b0;
`endif
    end else begin
      r_idex_live   <= 1'b1;
      r_idex_a      <= w_id_a;
      r_idex_b      <= w_id_b;
      r_idex_rs     <= w_rd_val;
      r_idex_rd     <= w_rd;
      r_idex_alu_op <= w_alu_op;
      r_idex_off    <= w_id_off;
      r_idex_pc1    <= r_ifid_pc1;
      r_idex_wr     <= w_wr;
      r_idex_wm     <= w_wm;
      r_idex_rm     <= w_rm;
      r_idex_neq    <= w_neq;
      r_idex_j      <= w_j;
      r_idex_jc     <= w_jc;
`ifdef EX_FWD_EN
      r_idex_a_src  <= w_sin ? 2'd0 : w_rd;
      r_idex_a_reg  <= !w_ina;
      r_idex_b_reg  <= !w_sout;
`endif
    end
  end

  // ---------------------------------------------------------------- EX
  logic       r_zero;
  logic [7:0] r_ac;
  logic [7:0] r_tgt;
  logic [7:0] r_rs;
  logic [1:0] r_rd;
  logic       r_wr, r_wm, r_rm, r_neq, r_j, r_jc;
  logic [7:0] w_a;
  logic [7:0] w_b;
  logic [7:0] w_rs;
  logic [7:0] w_res;
  logic [7:0] w_tgt;

`ifdef EX_FWD_EN
  // Loads (RMMem) are excluded: their value is not known until MEM.
  logic w_fwd_ok;
  assign w_fwd_ok = r_wr && !r_rm;
  assign w_a  = (r_idex_a_reg && w_fwd_ok && (r_rd == r_idex_a_src)) ? r_ac : r_idex_a;
  assign w_b  = (r_idex_b_reg && w_fwd_ok && (r_rd == 2'd0))         ? r_ac : r_idex_b;
  assign w_rs = (w_fwd_ok && (r_rd == r_idex_rd))                     ? r_ac : r_idex_rs;
`else
  assign w_a  = r_idex_a;
  assign w_b  = r_idex_b;
  assign w_rs = r_idex_rs;
`endif

  always_comb begin
    w_res = '0;
    case (r_idex_alu_op)
      3'd0: w_res = w_a + w_b;
      3'd1: w_res = w_a - w_b;
      3'd2: w_res = w_a & w_b;
      3'd3: w_res = w_a | w_b;
      3'd4: w_res = w_a ^ w_b;
      3'd5: w_res = ~w_a;
      3'd6: w_res = {w_a[6:0], 1'b0};
      3'd7: w_res = {1'b0, w_a[7:1]};
      default: w_res = w_a + w_b;
    endcase
  end

  assign w_tgt = r_idex_pc1 + r_idex_off;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_zero <= 1'b0; r_ac <= '0; r_tgt <= '0; r_rs <= '0; r_rd <= '0;
      r_wr <= 1'b0; r_wm <= 1'b0; r_rm <= 1'b0; r_neq <= 1'b0; r_j <= 1'b0; r_jc <= 1'b0;
    end else if (choice_mux || !r_idex_live) begin
      r_zero <= 1'b0; r_ac <= '0; r_tgt <= '0; r_rs <= '0; r_rd <= '0;
      r_wr <= 1'b0; r_wm <= 1'b0; r_rm <= 1'b0; r_neq <= 1'b0; r_j <= 1'b0; r_jc <= 1'b0;
    end else begin
      r_zero <= (w_res == 8'h00);
      r_ac   <= w_res;
      r_tgt  <= w_tgt;
      r_rs   <= w_rs;
      r_rd   <= r_idex_rd;
      r_wr   <= r_idex_wr;
      r_wm   <= r_idex_wm;
      r_rm   <= r_idex_rm;
      r_neq  <= r_idex_neq;
      r_j    <= r_idex_j;
      r_jc   <= r_idex_jc;
    end
  end

  assign zeroOut    = r_zero;
  assign acOutValue = r_ac;
  assign ulaJumpOut = r_tgt;
  assign rs         = r_rs;
  assign rdOut      = r_rd;
  assign WRMem      = r_wr;
  assign WMMem      = r_wm;
  assign RMMem      = r_rm;
  assign NEQMem     = r_neq;
  assign JMem       = r_j;
  assign JCMem      = r_jc;

endmodule

// File: tb/tb_if_id_ex_front.sv
// ---------------------------------------------------------------------------
// tb_if_id_ex_front
//   Drives if_id_ex_front from an instruction memory array with random
//   programs, random writebacks and random redirects. Expected EX/MEM state
//   per clock edge is produced by a reference model and queued; a monitor
//   pops one entry after every rising edge and compares.
// ---------------------------------------------------------------------------
module tb_if_id_ex_front;

  localparam bit FWD_EN =
`ifdef EX_FWD_EN
    1'b1;
`else
    1'b0;
`endif

  logic       clock;
  logic       rst_n;
  logic [7:0] imem_addr;
  logic [7:0] imem_data;
  logic [7:0] pcj_mux;
  logic       choice_mux;
  logic [7:0] wb_data;
  logic       wb_we;
  logic [1:0] wb_rd;
  logic       zeroOut;
  logic [7:0] acOutValue;
  logic [7:0] ulaJumpOut;
  logic [7:0] rs;
  logic [1:0] rdOut;
  logic       WRMem, WMMem, RMMem, NEQMem, JMem, JCMem;

  logic [7:0] imem [0:255];
  assign imem_data = imem[imem_addr];

  if_id_ex_front dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .pcj_mux    (pcj_mux),
    .choice_mux (choice_mux),
    .wb_data    (wb_data),
    .wb_we      (wb_we),
    .wb_rd      (wb_rd),
    .zeroOut    (zeroOut),
    .acOutValue (acOutValue),
    .ulaJumpOut (ulaJumpOut),
    .rs         (rs),
    .rdOut      (rdOut),
    .WRMem      (WRMem),
    .WMMem      (WMMem),
    .RMMem      (RMMem),
    .NEQMem     (NEQMem),
    .JMem       (JMem),
    .JCMem      (JCMem)
  );

  // ------------------------------------------------------------ clock/reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ------------------------------------------------------------ scoreboard
  typedef struct packed {
    logic [7:0] pc;
    logic [7:0] ac;
    logic [7:0] tgt;
    logic [7:0] rs;
    logic [1:0] rd;
    logic       zero, wr, wm, rm, neq, j, jc;
    logic       chk_ac, chk_tgt, chk_rs;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic mon_en = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------ reference model
  logic [7:0] m_regs [0:3];
  logic [7:0] m_pc;
  logic [7:0] id_ins, id_pc1;
  logic [7:0] ex_ins, ex_pc1, ex_rdv, ex_r0v;
  exp_t       m_last;

  function automatic exp_t nop_exp();
    exp_t e;
    e = '0;
    e.chk_ac = 1'b1; e.chk_tgt = 1'b1; e.chk_rs = 1'b1;
    return e;
  endfunction

  function automatic logic [7:0] alu_ref(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b);
    case (f)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ~a;
      3'd6: return a << 1;
      default: return a >> 1;
    endcase
  endfunction

  // Value seen by EX for a source register, given the instruction ahead of it.
  function automatic logic [7:0] fwd(input logic [7:0] v, input logic [1:0] src, input exp_t prev);
    if (FWD_EN && prev.wr && !prev.rm && prev.rd == src) return prev.ac;
    return v;
  endfunction

  function automatic exp_t model_ex(input logic [7:0] ins, input logic [7:0] pc1,
                                    input logic [7:0] rdv, input logic [7:0] r0v, input exp_t prev);
    exp_t e;
    logic [7:0] sx3, sx5, a_rd, a_r0;
    logic [1:0] rd;
    e = nop_exp();
    if (ins == 8'h00) return e;
    rd   = ins[4:3];
    sx3  = {{5{ins[2]}}, ins[2:0]};
    sx5  = {{3{ins[4]}}, ins[4:0]};
    a_rd = fwd(rdv, rd, prev);
    a_r0 = fwd(r0v, 2'd0, prev);
    e.rd = rd; e.chk_ac = 1'b1; e.chk_tgt = 1'b0; e.chk_rs = 1'b0;
    case (ins[7:5])
      3'd0: begin e.ac = alu_ref(ins[2:0], a_rd, a_r0); e.wr = 1'b1; end
      3'd1: begin e.ac = a_rd + sx3; e.wr = 1'b1; end
      3'd2: begin e.ac = sx3; e.wr = 1'b1; end
      3'd3: begin e.ac = a_r0 + sx3; e.wr = 1'b1; e.rm = 1'b1; end
      3'd4: begin e.ac = a_r0 + sx3; e.wm = 1'b1; e.rs = a_rd; e.chk_rs = 1'b1; end
      3'd5: begin e.j = 1'b1; e.chk_ac = 1'b0; e.chk_tgt = 1'b1; e.tgt = pc1 + sx5; end
      default: begin
        e.ac = a_rd - a_r0; e.jc = 1'b1; e.neq = ins[5];
        e.chk_tgt = 1'b1; e.tgt = pc1 + sx3;
      end
    endcase
    e.zero = (e.ac == 8'h00);
    return e;
  endfunction

  task automatic model_init();
    for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
    m_pc = 8'h00;
    id_ins = 8'h00; id_pc1 = 8'h00;
    ex_ins = 8'h00; ex_pc1 = 8'h00; ex_rdv = 8'h00; ex_r0v = 8'h00;
    m_last = nop_exp();
  endtask

  // ------------------------------------------------------------ monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (mon_en) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL queue_empty: got no expectation, required one");
        end else begin
          e = exp_q.pop_front();
          chk("imem_addr", imem_addr, e.pc);
          chk("rdOut", {6'd0, rdOut}, {6'd0, e.rd});
          chk("flags", {2'd0, WRMem, WMMem, RMMem, NEQMem, JMem, JCMem},
                       {2'd0, e.wr, e.wm, e.rm, e.neq, e.j, e.jc});
          if (e.chk_ac) begin
            chk("acOutValue", acOutValue, e.ac);
            chk("zeroOut", {7'd0, zeroOut}, {7'd0, e.zero});
          end
          if (e.chk_tgt) chk("ulaJumpOut", ulaJumpOut, e.tgt);
          if (e.chk_rs)  chk("rs", rs, e.rs);
        end
      end
    end
  end

  // ------------------------------------------------------------ driver tasks
  // Called at a falling edge: applies inputs, advances the model across the
  // next rising edge, queues the expectation, then waits for the next fall.
  task automatic step(input logic ch, input logic [7:0] pj, input logic we,
                      input logic [1:0] wr_i, input logic [7:0] wd);
    exp_t nl;
    choice_mux = ch; pcj_mux = pj; wb_we = we; wb_rd = wr_i; wb_data = wd;
    if (ch) begin
      nl = nop_exp();
      ex_ins = 8'h00; ex_pc1 = 8'h00;
      id_ins = 8'h00; id_pc1 = 8'h00;
      m_pc = pj;
    end else begin
      nl = model_ex(ex_ins, ex_pc1, ex_rdv, ex_r0v, m_last);
      ex_ins = id_ins; ex_pc1 = id_pc1;
      ex_rdv = (we && wr_i == id_ins[4:3]) ? wd : m_regs[id_ins[4:3]];
      ex_r0v = (we && wr_i == 2'd0) ? wd : m_regs[0];
      id_ins = imem[m_pc]; id_pc1 = m_pc + 8'd1;
      m_pc = m_pc + 8'd1;
    end
    if (we) m_regs[wr_i] = wd;
    nl.pc = m_pc;
    exp_q.push_back(nl);
    m_last = nl;
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00, 1'b0, 2'd0, 8'h00);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    rst_n = 1'b0;
    choice_mux = 1'b0; pcj_mux = 8'h00; wb_we = 1'b0; wb_rd = 2'd0; wb_data = 8'h00;
    #1;
    chk("rst_imem_addr", imem_addr, 8'h00);
    chk("rst_ac", acOutValue, 8'h00);
    chk("rst_tgt", ulaJumpOut, 8'h00);
    chk("rst_rs", rs, 8'h00);
    chk("rst_misc", {1'b0, zeroOut, rdOut, WRMem, WMMem, RMMem, NEQMem}, 8'h00);
    chk("rst_j", {6'd0, JMem, JCMem}, 8'h00);
    @(negedge clock);
    @(negedge clock);
    model_init();
    exp_q.delete();
    rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 8'h00;
  endtask

  // ------------------------------------------------------------ stimulus
  initial begin
    rst_n = 1'b0;
    choice_mux = 1'b0; pcj_mux = 8'h00; wb_we = 1'b0; wb_rd = 2'd0; wb_data = 8'h00;
    clear_imem();
    model_init();
    @(negedge clock);

    // LI R1,3 at address 0
    clear_imem(); imem[0] = 8'h4B;
    do_reset();
    idle(3);
    chk("li_ac", acOutValue, 8'h03);
    chk("li_rd", {6'd0, rdOut}, 8'h01);
    chk("li_wr", {7'd0, WRMem}, 8'h01);
    chk("li_zero", {7'd0, zeroOut}, 8'h00);

    // R1=3 by writeback, then ADDI R1,-3
    clear_imem(); imem[0] = 8'h2D;
    do_reset();
    step(1'b0, 8'h00, 1'b1, 2'd1, 8'h03);
    idle(2);
    chk("addi_ac", acOutValue, 8'h00);
    chk("addi_zero", {7'd0, zeroOut}, 8'h01);

    // J +4 at address 2, then redirect to 7; younger LIs must be squashed
    clear_imem(); imem[2] = 8'hA4; imem[3] = 8'h4B; imem[4] = 8'h4B; imem[5] = 8'h4B;
    imem[7] = 8'h53;
    do_reset();
    idle(5);
    chk("j_tgt", ulaJumpOut, 8'h07);
    chk("j_flag", {7'd0, JMem}, 8'h01);
    step(1'b1, 8'h07, 1'b0, 2'd0, 8'h00);
    chk("redir_addr", imem_addr, 8'h07);
    for (int k = 0; k < 3; k++) begin
      chk("squash_flags", {2'd0, WRMem, WMMem, RMMem, NEQMem, JMem, JCMem}, 8'h00);
      idle(1);
    end

    // R0=5, R2=5, BNE R2 at address 4
    clear_imem(); imem[4] = 8'hF1;
    do_reset();
    step(1'b0, 8'h00, 1'b1, 2'd0, 8'h05);
    step(1'b0, 8'h00, 1'b1, 2'd2, 8'h05);
    idle(5);
    chk("bne_zero", {7'd0, zeroOut}, 8'h01);
    chk("bne_flags", {6'd0, NEQMem, JCMem}, 8'h03);
    chk("bne_tgt", ulaJumpOut, 8'h06);

    // SW R3 with R0=8, R3=0x55 at address 2
    clear_imem(); imem[2] = 8'h98;
    do_reset();
    step(1'b0, 8'h00, 1'b1, 2'd0, 8'h08);
    step(1'b0, 8'h00, 1'b1, 2'd3, 8'h55);
    idle(3);
    chk("sw_ac", acOutValue, 8'h08);
    chk("sw_rs", rs, 8'h55);
    chk("sw_wm_wr", {6'd0, WMMem, WRMem}, 8'h02);

    // LI R1,3 followed directly by ADD R1 (R1 = R1 + R0)
    clear_imem(); imem[0] = 8'h4B; imem[1] = 8'h08;
    do_reset();
    idle(4);
`ifdef EX_FWD_EN
    chk("fwd_add", acOutValue, 8'h03);
`endif

    // PC wrap from 8'hFF to 8'h00
    clear_imem(); imem[8'hFE] = 8'h4A; imem[8'hFF] = 8'h2B;
    do_reset();
    step(1'b1, 8'hFE, 1'b0, 2'd0, 8'h00);
    idle(2);
    chk("pc_wrap", imem_addr, 8'h00);
    idle(3);

    // Random programs with random writebacks and redirects
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 256; i++) imem[i] = 8'($urandom);
      do_reset();
      for (int c = 0; c < 300; c++) begin
        step(($urandom_range(0, 11) == 0), 8'($urandom), 1'($urandom_range(0, 1)),
             2'($urandom), 8'($urandom));
      end
    end

    mon_en = 1'b0;
    @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
